// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM states, port ids and sizing helper
// shared by the two-port memory burst arbiter.
`timescale 1ns/1ps
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic int calc_len_w(input int block_size);
        return $clog2(block_size) + 1;
    endfunction

endpackage

// File: rtl/mem_arb_req_slot.sv
// mem_arb_req_slot: one-deep request latch per port with
// overflow detection for pulses that find the slot full.
`timescale 1ns/1ps
module mem_arb_req_slot
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_W-1:0]      len,
    input  logic                  clr,
    output logic                  pending,
    output logic [ADDR_WIDTH-1:0] addr_q,
    output logic [LEN_W-1:0]      len_q,
    output logic                  overflow
);

    logic accept;

    // a slot being freed this cycle can take a new pulse
    assign accept = req && (!pending || clr);

    // pending flag, latched request and drop pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= req && pending && !clr;
            if (accept) begin
                pending <= 1'b1;
                addr_q  <= addr;
                len_q   <= len;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: shares one burst memory port between the
// icache (0) and dcache (1) refills. MEM_ARB_RR_EN: round-robin.
`timescale 1ns/1ps
module mem_burst_arbiter
    import mem_arb_pkg::*;
#(
    parameter int  ADDR_WIDTH = 32,
    parameter int  DATA_WIDTH = 32,
    parameter int  BLOCK_SIZE = 8,
    localparam int LEN_W      = calc_len_w(BLOCK_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s0_req,
    input  logic [ADDR_WIDTH-1:0] s0_addr,
    input  logic [LEN_W-1:0]      s0_burst_len,
    output logic                  s0_ready,
    output logic                  s0_valid,
    output logic                  s0_last,
    output logic [DATA_WIDTH-1:0] s0_data,
    input  logic                  s1_req,
    input  logic [ADDR_WIDTH-1:0] s1_addr,
    input  logic [LEN_W-1:0]      s1_burst_len,
    output logic                  s1_ready,
    output logic                  s1_valid,
    output logic                  s1_last,
    output logic [DATA_WIDTH-1:0] s1_data,
    output logic                  m_req,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [LEN_W-1:0]      m_burst_len,
    input  logic                  m_ready,
    input  logic                  m_valid,
    input  logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_last,
    output logic                  busy,
    output logic                  grant_id,
    output logic                  err_overflow
);

    state_t                state;
    logic                  gnt;
    logic [LEN_W-1:0]      beat_cnt;
    logic                  p0, p1;
    logic [ADDR_WIDTH-1:0] a0, a1;
    logic [LEN_W-1:0]      l0, l1;
    logic                  ovf0, ovf1;
    logic                  clr0, clr1;
    logic [LEN_W-1:0]      gnt_len;
    logic                  term_hit;
    logic                  done;
    logic                  winner;

    mem_arb_req_slot #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_W     (LEN_W)
    ) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .req     (s0_req),
        .addr    (s0_addr),
        .len     (s0_burst_len),
        .clr     (clr0),
        .pending (p0),
        .addr_q  (a0),
        .len_q   (l0),
        .overflow(ovf0)
    );

    mem_arb_req_slot #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_W     (LEN_W)
    ) u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .req     (s1_req),
        .addr    (s1_addr),
        .len     (s1_burst_len),
        .clr     (clr1),
        .pending (p1),
        .addr_q  (a1),
        .len_q   (l1),
        .overflow(ovf1)
    );

    assign gnt_len  = gnt ? l1 : l0;
    // a beat ends the burst on m_last or on the counted final beat
    assign term_hit = m_valid && (m_last || beat_cnt == gnt_len);
    assign done     = (state == BURST) && term_hit;
    assign clr0     = done && (gnt == PORT0);
    assign clr1     = done && (gnt == PORT1);

`ifdef MEM_ARB_RR_EN
    logic last_gnt;

    assign winner = (p0 && p1) ? ~last_gnt : p1;

    // remember who won so the other port wins the next tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= PORT1;
        end else if (state == IDLE && (p0 || p1)) begin
            last_gnt <= winner;
        end
    end
`else
    assign winner = p1;
`endif

    // grant / request / burst sequencing, one burst in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt         <= PORT0;
            beat_cnt    <= '0;
            m_req       <= 1'b0;
            m_addr      <= '0;
            m_burst_len <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (p0 || p1) begin
                        gnt         <= winner;
                        state       <= REQ;
                        m_req       <= 1'b1;
                        m_addr      <= winner ? a1 : a0;
                        m_burst_len <= winner ? l1 : l0;
                    end
                end
                REQ: begin
                    if (m_ready) begin
                        state       <= BURST;
                        beat_cnt    <= '0;
                        m_req       <= 1'b0;
                        m_addr      <= '0;
                        m_burst_len <= '0;
                    end
                end
                BURST: begin
                    if (term_hit) begin
                        state <= IDLE;
                    end else if (m_valid) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s0_ready     = !p0;
    assign s1_ready     = !p1;
    assign s0_valid     = m_valid && state == BURST && gnt == PORT0;
    assign s1_valid     = m_valid && state == BURST && gnt == PORT1;
    assign s0_last      = s0_valid && term_hit;
    assign s1_last      = s1_valid && term_hit;
    assign s0_data      = m_data;
    assign s1_data      = m_data;
    assign busy         = (state != IDLE) || p0 || p1;
    assign grant_id     = gnt;
    assign err_overflow = ovf0 || ovf1;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb_mem_burst_arbiter: randomized memory model, request model
// and beat scoreboard for mem_burst_arbiter.
`timescale 1ns/1ps
module tb_mem_burst_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BS = 8;
    localparam int LW = $clog2(BS) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          s0_req, s1_req;
    logic [AW-1:0] s0_addr, s1_addr;
    logic [LW-1:0] s0_burst_len, s1_burst_len;
    logic          s0_ready, s0_valid, s0_last;
    logic          s1_ready, s1_valid, s1_last;
    logic [DW-1:0] s0_data, s1_data;
    logic          m_req, m_ready, m_valid, m_last;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_burst_len;
    logic [DW-1:0] m_data;
    logic          busy, grant_id, err_overflow;

    mem_burst_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .BLOCK_SIZE(BS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s0_req      (s0_req),
        .s0_addr     (s0_addr),
        .s0_burst_len(s0_burst_len),
        .s0_ready    (s0_ready),
        .s0_valid    (s0_valid),
        .s0_last     (s0_last),
        .s0_data     (s0_data),
        .s1_req      (s1_req),
        .s1_addr     (s1_addr),
        .s1_burst_len(s1_burst_len),
        .s1_ready    (s1_ready),
        .s1_valid    (s1_valid),
        .s1_last     (s1_last),
        .s1_data     (s1_data),
        .m_req       (m_req),
        .m_addr      (m_addr),
        .m_burst_len (m_burst_len),
        .m_ready     (m_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          pid;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t beat_q[$];
    int    gnt_log[$];

    int n_checks = 0;
    int n_pass = 0;

    // request model: what each port has asked for
    bit            pend[2];
    bit            inflight[2];
    logic [AW-1:0] paddr[2];
    logic [LW-1:0] plen[2];
    int            last_g = 1;
    int            ovf_exp = 0;
    int            ovf_seen = 0;
    int            n_grants = 0;
    int            beats_seen = 0;
    int            cyc = 0;
    int            last_end_cyc = 0;
    int            gap_meas = 0;

    // memory model knobs
    bit            dir_en = 1'b1;
    int            dir_mode = 0;
    int            dir_extra = 0;
    logic [DW-1:0] dir_base = '0;
    bit            aborted = 1'b0;
    bit            drv_idle = 1'b1;

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h",
                      name, got, exp);
    endtask

    task automatic model_req(input int p,
                             input logic [AW-1:0] a,
                             input logic [LW-1:0] l);
        if (pend[p] || inflight[p]) begin
            ovf_exp++;
        end else begin
            pend[p]  = 1'b1;
            paddr[p] = a;
            plen[p]  = l;
        end
    endtask

    task automatic model_reset();
        pend[0] = 0; pend[1] = 0;
        inflight[0] = 0; inflight[1] = 0;
        last_g = 1;
    endtask

    // decide the winner from the pending set and check the request
    task automatic model_pick(output int w,
                              output logic [LW-1:0] l);
        if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_RR_EN
            w = (last_g == 1) ? 0 : 1;
`else
            w = 1;
`endif
        end else if (pend[1]) begin
            w = 1;
        end else begin
            w = 0;
        end
        if (!pend[w]) begin
            n_checks++;
            $display("FAIL spurious_m_req: addr=0x%0h, no pending request",
                     m_addr);
        end
        chk("grant_id", grant_id, w);
        chk("busy_in_req", busy, 1);
        chk("m_addr", m_addr, paddr[w]);
        chk("m_burst_len", m_burst_len, plen[w]);
        l = plen[w];
        pend[w] = 1'b0;
        inflight[w] = 1'b1;
        last_g = w;
        n_grants++;
        gnt_log.push_back(w);
    endtask

    task automatic pulse(input bit e0, input logic [AW-1:0] a0,
                         input logic [LW-1:0] l0,
                         input bit e1, input logic [AW-1:0] a1,
                         input logic [LW-1:0] l1);
        @(posedge clk); #1;
        s0_req = e0; s0_addr = a0; s0_burst_len = l0;
        s1_req = e1; s1_addr = a1; s1_burst_len = l1;
        if (e0) model_req(0, a0, l0);
        if (e1) model_req(1, a1, l1);
        @(posedge clk); #1;
        s0_req = 0; s0_addr = '0; s0_burst_len = '0;
        s1_req = 0; s1_addr = '0; s1_burst_len = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        bit ok;
        n = 0;
        ok = 0;
        while (n < 1000 && !ok) begin
            @(negedge clk);
            n++;
            ok = !busy && drv_idle && beat_q.size() == 0 &&
                 !pend[0] && !pend[1] &&
                 !inflight[0] && !inflight[1];
        end
        chk({tag, "_done"}, ok, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_m_req"}, m_req, 0);
        chk({tag, "_m_addr"}, m_addr, 0);
        chk({tag, "_m_len"}, m_burst_len, 0);
        chk({tag, "_s0_ready"}, s0_ready, 1);
        chk({tag, "_s1_ready"}, s1_ready, 1);
        chk({tag, "_s0_valid"}, s0_valid, 0);
        chk({tag, "_s1_valid"}, s1_valid, 0);
        chk({tag, "_s0_last"}, s0_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant"}, grant_id, 0);
        chk({tag, "_ovf"}, err_overflow, 0);
    endtask

    // downstream memory: accepts requests, returns beats
    initial begin : mem_drv
        int            dly, w, mode, extra, term, gap;
        logic [LW-1:0] l;
        logic [DW-1:0] d;
        beat_t         b;
        m_ready = 0; m_valid = 0; m_last = 0; m_data = '0;
        forever begin
            @(posedge clk); #1;
            if (!(m_req && !rst)) begin
                drv_idle = 1'b1;
            end else begin
                drv_idle = 1'b0;
                dly = dir_en ? 0 : $urandom_range(0, 2);
                repeat (dly) begin @(posedge clk); #1; end
                m_ready = 1'b1;
                model_pick(w, l);
                @(posedge clk); #1;
                m_ready = 1'b0;
                if (dir_en) begin
                    mode = dir_mode;
                    extra = dir_extra;
                end else begin
                    mode = $urandom_range(0, 2);
                    extra = $urandom_range(0, 2);
                end
                term = (mode == 2) ? $urandom_range(0, int'(l))
                                   : int'(l);
                for (int i = 0; i <= term + extra; i++) begin
                    gap = (!dir_en && $urandom_range(0, 3) == 0) ? 1 : 0;
                    repeat (gap) begin @(posedge clk); #1; end
                    d = dir_en ? dir_base + 32'(i) : $urandom;
                    m_valid = 1'b1;
                    m_data = d;
                    m_last = (mode != 1) && (i == term);
                    if (i <= term && !aborted) begin
                        b.pid = w[0];
                        b.data = d;
                        b.last = (i == term);
                        beat_q.push_back(b);
                    end
                    @(posedge clk); #1;
                    m_valid = 1'b0;
                    m_last = 1'b0;
                end
                if (!aborted) inflight[w] = 1'b0;
            end
        end
    end

    // monitor: every forwarded beat must match the scoreboard
    initial begin : mon
        beat_t b;
        logic  req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (err_overflow) ovf_seen++;
            if (s0_valid || s1_valid) begin
                beats_seen++;
                if (s0_valid && s1_valid) begin
                    n_checks++;
                    $display("FAIL both_valid: s0_valid=1 s1_valid=1, want one");
                end else if (beat_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: s0=%0d s1=%0d data=0x%0h, none expected",
                             s0_valid, s1_valid, m_data);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_port", s1_valid, b.pid);
                    chk("beat_data", s1_valid ? s1_data : s0_data, b.data);
                    chk("beat_last", s1_valid ? s1_last : s0_last, b.last);
                end
                if (s0_last || s1_last) last_end_cyc = cyc;
            end
            if ((s0_last && !s0_valid) || (s1_last && !s1_valid)) begin
                n_checks++;
                $display("FAIL last_no_valid: s0_last=%0d s1_last=%0d without valid",
                         s0_last, s1_last);
            end
            if (!m_req && (m_addr != '0 || m_burst_len != '0)) begin
                n_checks++;
                $display("FAIL idle_m_addr: addr=0x%0h len=%0d with m_req=0, want 0",
                         m_addr, m_burst_len);
            end
            if (m_req && !req_prev) gap_meas = cyc - last_end_cyc;
            req_prev = m_req;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int            base, g0, n, lose, k;
        logic [AW-1:0] ra0, ra1;
        logic [LW-1:0] rl0, rl1;
        rst = 1'b1;
        s0_req = 0; s0_addr = '0; s0_burst_len = '0;
        s1_req = 0; s1_addr = '0; s1_burst_len = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", busy, 0);

        // single icache refill with exact latency
        dir_en = 1; dir_mode = 0; dir_extra = 0; dir_base = 32'hA0;
        base = beats_seen;
        pulse(1, 32'h100, 4'd7, 0, '0, '0);
        @(negedge clk);
        chk("t1_req_T1", m_req, 0);
        chk("t1_s0_ready", s0_ready, 0);
        @(negedge clk);
        chk("t1_req_T2", m_req, 1);
        chk("t1_addr_T2", m_addr, 32'h100);
        wait_idle("t1");
        chk("t1_beats", beats_seen - base, 8);
        chk("t1_s0_ready_end", s0_ready, 1);

        // simultaneous requests, three rounds
        for (int r = 0; r < 3; r++) begin
            dir_base = 32'hC0 + 32'(r * 16);
            g0 = n_grants;
            pulse(1, 32'h200, 4'd3, 1, 32'h300, 4'd3);
            @(negedge clk);
            chk("t3_s0_ready", s0_ready, 0);
            chk("t3_s1_ready", s1_ready, 0);
            n = 0;
            while (n < 200 && n_grants < g0 + 2) begin
                @(negedge clk);
                n++;
            end
            chk("t3_second_grant", n_grants >= g0 + 2, 1);
            lose = gnt_log[gnt_log.size() - 1];
            chk("t3_loser_ready",
                (lose == 1) ? s1_ready : s0_ready, 0);
            wait_idle("t3");
            chk("t3_idle_gap", gap_meas, 2);
            chk("t3_ready_end", {s1_ready, s0_ready}, 2'b11);
        end

        // second pulse while pending is dropped
        dir_base = 32'hD0;
        @(posedge clk); #1;
        s0_req = 1; s0_addr = 32'h400; s0_burst_len = 4'd5;
        model_req(0, 32'h400, 4'd5);
        @(posedge clk); #1;
        s0_addr = 32'h480; s0_burst_len = 4'd2;
        model_req(0, 32'h480, 4'd2);
        @(posedge clk); #1;
        s0_req = 0; s0_addr = '0; s0_burst_len = '0;
        @(negedge clk);
        chk("ovf_pulse", err_overflow, 1);
        @(negedge clk);
        chk("ovf_one_cycle", err_overflow, 0);
        wait_idle("ovf");
        chk("ovf_count", ovf_seen, ovf_exp);

        // downstream never raises m_last and overruns
        dir_mode = 1; dir_extra = 2; dir_base = 32'hE0;
        base = beats_seen;
        pulse(1, 32'h180, 4'd7, 0, '0, '0);
        wait_idle("nolast");
        chk("nolast_beats", beats_seen - base, 8);

        // reset during the third beat
        dir_mode = 0; dir_extra = 0; dir_base = 32'hF0;
        base = beats_seen;
        pulse(1, 32'h500, 4'd7, 0, '0, '0);
        n = 0;
        while (n < 200 && beats_seen < base + 3) begin
            @(negedge clk); #1;
            n++;
        end
        chk("rst_reach_beat3", beats_seen - base, 3);
        #1;
        rst = 1'b1;
        aborted = 1'b1;
        #1;
        check_reset("rst_mid");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        @(negedge clk);
        while (n < 200 && !drv_idle) begin
            @(negedge clk);
            n++;
        end
        aborted = 1'b0;
        chk("rst_beats_dropped", beats_seen - base, 3);
        chk("rst_busy", busy, 0);
        base = beats_seen;
        dir_base = 32'h60;
        pulse(1, 32'h600, 4'd3, 0, '0, '0);
        wait_idle("rst_fresh");
        chk("rst_fresh_beats", beats_seen - base, 4);

        // randomized traffic
        dir_en = 0;
        for (int r = 0; r < 30; r++) begin
            k = $urandom_range(0, 2);
            ra0 = $urandom & ~32'h1F;
            ra1 = $urandom & ~32'h1F;
            rl0 = LW'($urandom_range(0, BS - 1));
            rl1 = LW'($urandom_range(0, BS - 1));
            pulse(k != 1, ra0, rl0, k != 0, ra1, rl1);
            wait_idle("rand");
        end
        chk("final_ovf_count", ovf_seen, ovf_exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_burst_arbiter.md
Name: mem_burst_arbiter

Overview:
- Two-requester arbiter sharing one burst-capable memory port between the instruction cache refill path (port 0) and the data-side refill path (port 1).
- Latches single-cycle miss-request pulses, grants one burst at a time, and routes returning beats only to the granted requester.
- Sits between the L1 caches and the external memory model/controller.

Parameters:
ADDR_WIDTH, 32, address width on all ports
DATA_WIDTH, 32, beat data width
BLOCK_SIZE, 8, max words per burst; localparam LEN_W = $clog2(BLOCK_SIZE)+1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
s0_req  in  1  port 0 burst request pulse (icache)
s0_addr  in  ADDR_WIDTH  port 0 block-aligned address
s0_burst_len  in  LEN_W  port 0 beats minus one
s0_ready  out  1  port 0 pending slot empty
s0_valid  out  1  beat valid to port 0
s0_last  out  1  final beat to port 0
s0_data  out  DATA_WIDTH  beat data (shared with port 1)
s1_req, s1_addr, s1_burst_len, s1_ready, s1_valid, s1_last, s1_data  same as port 0 for port 1
m_req  out  1  downstream request
m_addr  out  ADDR_WIDTH  downstream address
m_burst_len  out  LEN_W  downstream beats minus one
m_ready  in  1  downstream accepts request when m_req && m_ready
m_valid  in  1  downstream beat valid
m_data  in  DATA_WIDTH  downstream beat data
m_last  in  1  downstream final beat
busy  out  1  state != IDLE or any pending
grant_id  out  1  port currently granted (valid when busy)
err_overflow  out  1  one-cycle pulse: request dropped

Behaviour:
- Reset (asynchronous): state=IDLE; both pending flags, grant_id, and the beat counter = 0; all outputs 0 except s0_ready=s1_ready=1. Reset mid-burst abandons the burst; later downstream beats are ignored.
- Capture: sN_req while pendingN==0 latches addr/len and sets pendingN at the next edge. Requesters do not hold req; a pulse is sufficient. sN_ready = !pendingN.
- sN_req while pendingN==1 is dropped, and err_overflow pulses the next cycle. Exception: a request in the same cycle that pendingN is cleared by burst completion is accepted.
- FSM states:
  - IDLE: if any pending, select a winner, register grant_id, go to REQ.
  - REQ: m_req=1, m_addr/m_burst_len = winner's latched values. On m_ready go to BURST with beat_cnt=0.
  - BURST: each m_valid increments beat_cnt. Burst ends on m_valid && (m_last || beat_cnt==len). On end: clear pending[grant], go to IDLE.
- Latency: pulse at cycle T -> pending at T+1 -> m_req first high at T+2. Back-to-back grants insert one IDLE cycle.
- Routing (combinational): sN_valid = m_valid && state==BURST && grant_id==N.
- sN_last is high on the terminating beat only: it is asserted if m_last or the count is reached, so the requester always sees a last beat.
- sN_data = m_data for both ports.
- m_valid outside BURST is ignored and never forwarded.
- m_req never exceeds one outstanding burst. m_addr/m_burst_len are 0 when m_req=0.
- Width rule: beat_cnt is LEN_W bits. len=BLOCK_SIZE-1 yields exactly BLOCK_SIZE beats. Excess beats after termination are ignored.
- Simultaneous first requests on both ports: both latch; the priority rule picks the winner. The loser stays pending and is granted next.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin; the port granted last gets lowest priority on the next contested selection. The last-grant register resets to port 1, so port 0 wins the first tie.
- Undefined: fixed priority, port 1 (data) always wins ties. No last-grant register.

Decomposition:
- Shared package mem_arb_pkg: FSM state encoding (IDLE/REQ/BURST), port index constants, LEN_W derivation function.
- One natural sub-module: mem_arb_req_slot (pending flag + addr/len latch + overflow detect), instantiated per port.

Test Plan:
- Single port 0 pulse, addr 0x100, len 7; downstream m_ready immediately, 8 beats 0xA0..0xA7 with m_last on 8th -> m_req at T+2 with addr 0x100; s0_valid for 8 beats, s0_last on 0xA7; s1_valid never high.
- Simultaneous s0/s1 pulses (0x200, 0x300), fixed priority -> port 1 burst first, then port 0 after one IDLE cycle; s0_ready low until its burst ends.
- Same stimulus with MEM_ARB_RR_EN, repeated three times -> grants alternate 0,1,0,1,... with no starvation.
- s0 pulse while pending0 set -> err_overflow pulses once; original 0x400 request is served unchanged.
- Downstream omits m_last, sends 10 beats for len 7 -> burst ends on 8th beat with s0_last=1; beats 9-10 are not forwarded.
- rst asserted during beat 3 of a burst -> all outputs return to reset values asynchronously; a fresh request after reset completes normally.
